// File: rtl/hca28_limb_serial_adder.sv
// ---------------------------------------------------------------------------
// hca28_limb_serial_adder
//   Limb-serial multi-precision add/subtract. Each accepted limb pair goes
//   through one evaluation of a 28-bit Han-Carlson prefix adder. The limb's
//   carry out (sum bit W) is kept as the carry into the next limb of the same
//   operation.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/ready    input handshake for one limb pair
//   in_x, in_y        operand limbs, least significant limb first
//   in_first/in_last  operation framing
//   in_sub            X-Y when set; only looked at on a first limb
//   out_valid/ready   output handshake, single register stage
//   out_sum, out_idx  result limb and its index within the operation
//   out_last          final limb of the operation
//   out_cout          raw carry out of the limb (0 = borrow when subtracting)
//   out_err           framing / overlength error flagged on this limb
// ---------------------------------------------------------------------------

// Han-Carlson prefix adder with carry-in: {sum_o[W], sum_o[W-1:0]} = a + b + cin.
// Odd bits run a Kogge-Stone tree; even bits are fixed up with one last level.
module hca28_core #(
    parameter int W = 28
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W:0]   sum_o
);
    logic [W-1:0] g0, p0, g, p;

    always_comb begin
        g0 = a_i & b_i;
        p0 = a_i ^ b_i;
        g  = g0;
        p  = p0;
        // Folding cin into bit 0 makes every group generate G[i:0] the
        // carry into bit i+1 directly.
        g[0] = g0[0] | (p0[0] & cin_i);

        // Odd bits absorb their even neighbour.
        for (int i = W - 1; i >= 1; i--) begin
            if (i % 2 == 1) begin
                g[i] = g[i] | (p[i] & g[i-1]);
                p[i] = p[i] & p[i-1];
            end
        end

        // Kogge-Stone over odd bits. Descending order keeps g[i-d]/p[i-d]
        // at their previous-level values while updating in place.
        for (int d = 2; d < W; d = d * 2) begin
            for (int i = W - 1; i >= 1; i--) begin
                if ((i % 2 == 1) && (i >= d)) begin
                    g[i] = g[i] | (p[i] & g[i-d]);
                    p[i] = p[i] & p[i-d];
                end
            end
        end

        // Even bits take the finished prefix of the odd bit below them.
        for (int i = 2; i < W; i++) begin
            if (i % 2 == 0) begin
                g[i] = g0[i] | (p0[i] & g[i-1]);
            end
        end

        sum_o = {g[W-1], p0 ^ {g[W-2:0], cin_i}};
    end
endmodule

module hca28_limb_serial_adder #(
    parameter int W         = 28,
    parameter int MAX_LIMBS = 16,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic [CNT_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_err
);
    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [CNT_W-1:0] IDX_MAX = CNT_W'(MAX_LIMBS - 1);

    state_e           state_q, state_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             out_cout_q, out_cout_d;
    logic             out_err_q, out_err_d;

    logic             accept;
    logic             is_first;
    logic             sub_eff;
    logic             cin;
    logic [W-1:0]     y_eff;
    logic [CNT_W-1:0] idx_nxt;
    logic             err_nxt;
    logic [W:0]       core_sum;

    // Output register is the only buffer: a new limb enters only when the
    // held result is absent or leaving this cycle.
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // A limb arriving in IDLE is treated as first even without in_first.
    assign is_first = in_first || (state_q == IDLE);
    assign sub_eff  = is_first ? in_sub : sub_q;
    // Subtract is X + ~Y + 1, so the first-limb carry-in equals in_sub.
    assign cin      = is_first ? in_sub : carry_q;
    assign y_eff    = sub_eff ? ~in_y : in_y;
    assign idx_nxt  = is_first ? '0 :
                      (idx_q == IDX_MAX) ? IDX_MAX : idx_q + 1'b1;
    assign err_nxt  = ((state_q == IDLE) && !in_first) ||
                      ((state_q == RUN)  &&  in_first) ||
                      (!is_first && (idx_q == IDX_MAX));

    hca28_core #(.W(W)) u_core (
        .a_i   (in_x),
        .b_i   (y_eff),
        .cin_i (cin),
        .sum_o (core_sum)
    );

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_err_d   = out_err_q;

        if (accept) begin
            state_d     = in_last ? IDLE : RUN;
            carry_d     = core_sum[W];
            idx_d       = idx_nxt;
            if (is_first) begin
                sub_d = in_sub;
            end
            out_valid_d = 1'b1;
            out_sum_d   = core_sum[W-1:0];
            out_idx_d   = idx_nxt;
            out_last_d  = in_last;
            out_cout_d  = core_sum[W];
            out_err_d   = err_nxt;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_err   = out_err_q;
endmodule

// File: tb/tb_hca28_limb_serial_adder.sv
// Scoreboard bench: the driver pushes the expected result of each accepted
// limb; a monitor compares whatever the DUT presents against the queue head.
module tb_hca28_limb_serial_adder;
    localparam int W = 28;
    localparam logic [27:0] ONES = 28'hFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] in_x = '0;
    logic [27:0] in_y = '0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [27:0] out_sum;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        out_cout;
    logic        out_err;

    hca28_limb_serial_adder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y),
        .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last),
        .out_cout(out_cout), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0] sum;
        logic [3:0]  idx;
        logic        last;
        logic        cout;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;
    bit   started = 0;
    bit   bp_rand = 0;

    // Reference: operation-level view. Add tracks a carry, subtract tracks
    // a borrow, both with plain integer arithmetic.
    bit m_run = 0;
    bit m_sub = 0;
    bit m_cb = 0;
    int m_idx = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void issue(logic [27:0] x, logic [27:0] y, bit first, bit last, bit sub);
        exp_t   e;
        longint t;
        bit     isf;
        isf   = first || !m_run;
        e.err = (!m_run && !first) || (m_run && first) || (!isf && m_idx == 15);
        if (isf) begin
            m_sub = sub; m_cb = 0; m_idx = 0;
        end else begin
            m_idx = (m_idx == 15) ? 15 : m_idx + 1;
        end
        if (m_sub) begin
            t = longint'(x) - longint'(y) - longint'(m_cb);
            e.cout = (t >= 0);
            if (t < 0) t += 64'h1000_0000;
            m_cb = !e.cout;
        end else begin
            t = longint'(x) + longint'(y) + longint'(m_cb);
            e.cout = (t >= 64'h1000_0000);
            if (e.cout) t -= 64'h1000_0000;
            m_cb = e.cout;
        end
        e.sum  = t[27:0];
        e.idx  = 4'(m_idx);
        e.last = last;
        m_run  = !last;
        sb.push_back(e);
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [27:0] x, input logic [27:0] y,
                        input bit first, input bit last, input bit sub);
        int n = 0;
        bit done = 0;
        in_valid = 1'b1; in_x = x; in_y = y;
        in_first = first; in_last = last; in_sub = sub;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                issue(x, y, first, last, sub);
                done = 1;
            end else if (++n > 200) begin
                chk("accept_timeout", 64'(n), 64'(0));
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_x = '0; in_y = '0;
        in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_run = 0; m_sub = 0; m_cb = 0; m_idx = 0;
    endtask

    function automatic logic [27:0] pick();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return ONES;
            2:       return 28'($urandom);
            default: return 28'd1;
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'(0));
                end else begin
                    chk("result", 64'({out_sum, out_idx, out_last, out_cout, out_err}), 64'(sb[0]));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        if (bp_rand) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int wait_n;
        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_outs", 64'({out_valid, out_sum, out_idx, out_last, out_cout, out_err}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        started = 1;

        // 1. single add
        send(28'h5, 28'h3, 1, 1, 0);
        // 2. carry chain
        send(ONES, 28'h1, 1, 0, 0);
        send(28'h0, 28'h0, 0, 1, 0);
        // 3. subtract both signs
        send(28'h5, 28'h7, 1, 1, 1);
        send(28'h7, 28'h5, 1, 1, 1);
        // 4. backpressure
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                send(ONES, 28'h1, 1, 0, 0);
                send(ONES, 28'h0, 0, 0, 0);
                send(28'h0, 28'h0, 0, 1, 0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        // 5. overlength: 17 limbs, never last
        for (int k = 0; k < 17; k++) send(28'h0, 28'h0, k == 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 do_reset();
        // 6. reset mid-operation
        send(28'h10, 28'h20, 1, 0, 0);
        send(28'h30, 28'h40, 0, 0, 0);
        do_reset();
        chk("post_rst_valid", 64'(out_valid), 64'(0));
        send(28'h1, 28'h1, 0, 1, 0);

        // Randomized operations with random backpressure
        bp_rand = 1;
        for (int op = 0; op < 40; op++) begin
            int len;
            bit sub, bad;
            len = $urandom_range(1, 5);
            sub = $urandom_range(0, 1);
            bad = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < len; k++) begin
                send(pick(), pick(), (k == 0) && !bad, k == len - 1, sub);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        bp_rand = 0;
        @(posedge clk); #2 out_ready = 1'b1;

        wait_n = 0;
        while (sb.size() != 0 && wait_n < 200) begin
            @(posedge clk); wait_n++;
        end
        @(posedge clk); #1;
        chk("drain_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
